program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Streams a program image into instruction memory before the cellular-automaton core runs. It is the writer side of the 16-bit instruction format the core's fetch/decode consumes.
- Receives a byte stream over a valid/ready interface, parses a framed image, assembles big-endian 16-bit instructions and writes them to sequential instruction-memory addresses.
- While loading, it rejects illegal opcodes, out-of-range JUMP/CALL targets and bad checksums.
- Holds the core in stall via `busy` while loading.

Parameters:
- IMEM_DEPTH, 4096, number of instruction words. Maximum legal program length; at most 2^12.
- ADDR_W, 12, instruction address width (equals program counter length).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a frame load when idle or finished
- in_data  input  8  stream byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts byte; transfer occurs when in_valid && in_ready
- imem_we  output  1  instruction-memory write strobe
- imem_addr  output  ADDR_W  write address
- imem_data  output  16  instruction word
- busy  output  1  high from start acceptance until DONE/ERR; core must stall
- done  output  1  one-cycle pulse on successful completion
- error  output  1  sticky until next accepted start or reset
- error_code  output  3  0 none, 1 zero length, 2 illegal opcode, 3 branch target out of range, 4 checksum mismatch, 5 length > IMEM_DEPTH
- prog_len  output  13  instruction count of the last successful load (0 after reset or on error)

Behaviour:
- Frame layout:
  - LEN_HI, LEN_LO: N, 16-bit big-endian.
  - N instruction pairs (HI byte = bits 15:8, LO byte = bits 7:0).
  - CHK byte: must equal the XOR of all preceding frame bytes, including the length bytes.
- Reset values: all outputs 0; state IDLE; internal counters and running XOR 0. Reset mid-frame aborts the frame with no further writes; earlier writes are not undone.
- States: IDLE, LEN_HI, LEN_LO, INS_HI, INS_LO, CHECK, DONE, ERR.
- in_ready is 1 only in LEN_HI, LEN_LO, INS_HI, INS_LO and CHECK. It is registered and drops the cycle after the last byte of a phase that ends receiving.
- IDLE/DONE/ERR + start:
  - Enter LEN_HI; busy=1.
  - Clear error, error_code, XOR and index.
  - Clear prog_len only from ERR or IDLE.
  - start in any other state is ignored.
- LEN_LO accept:
  - N==0: go to ERR with code 1.
  - N>IMEM_DEPTH: go to ERR with code 5.
  - Otherwise go to INS_HI.
- INS_HI accept:
  - Latch the byte.
  - Opcode (byte[7:4]) == 4'hF: go to ERR with code 2. No write occurs for that word.
- INS_LO accept:
  - Form the word.
  - If the opcode is JUMP (C) or CALL (D) and the target field word[11:0] >= N: go to ERR with code 3. No write.
  - Else, in the next cycle: imem_we=1, imem_addr=index, imem_data=word, for exactly one cycle. Write latency is 1 cycle after the LO handshake.
  - Then increment index. After the Nth word go to CHECK, else go to INS_HI.
- RET, UNL and the ALU opcodes (0-B, E) are not range-checked.
- CHECK accept:
  - Byte == running XOR: go to DONE; done pulses one cycle; prog_len=N; busy=0.
  - Otherwise go to ERR with code 4.
- ERR: busy=0, error=1, in_ready=0. Bytes presented are not consumed. Words written before the error remain in memory.
- The running XOR updates on every accepted byte except CHK.
- in_valid low stalls any state indefinitely with no timeout; partial state is held.
- imem_addr/imem_data hold their last values when imem_we=0.

Test Plan:
- Good load:
  - Stimulus: start; bytes 00 02 01 05 21 12 35.
  - Required: writes addr0=0x0105 and addr1=0x2112, each one cycle after its LO byte; done pulse; prog_len=2; error=0; busy high from the cycle after start until done.
- Zero length:
  - Stimulus: start; bytes 00 00.
  - Required: ERR code 1; no imem_we; in_ready low; busy low. A new start then recovers with the good frame.
- Illegal opcode:
  - Stimulus: start; 00 02 01 05 F0.
  - Required: one write (addr0=0x0105); ERR code 2 immediately after the F0 byte; the following byte stays unconsumed.
- Branch range:
  - Stimulus: 00 01 C0 05 xx.
  - Required: ERR code 3, no write.
  - Stimulus: 00 01 C0 00 C1.
  - Required: write addr0=0xC000; done.
- Checksum and backpressure:
  - Stimulus: the good frame with CHK=0x36, with in_valid toggling every other cycle.
  - Required: both writes still occur; ERR code 4; prog_len=0.
- Reset and length limit:
  - Stimulus: assert rst after byte 4 of the good frame.
  - Required: all outputs 0 asynchronously; a subsequent full good frame loads correctly.
  - Stimulus: length 10 01 (4097).
  - Required: ERR code 5.

Source files
------------

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write bus for the program loader.
// master = stream source / memory side, slave = loader.
interface program_loader_if #(
    parameter int ADDR_W = 12
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_data;

    modport master (
        output in_data, in_valid,
        input  in_ready, imem_we, imem_addr, imem_data
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, imem_we, imem_addr, imem_data
    );
endinterface

// File: rtl/program_loader.sv
// Parses a framed program image (length, big-endian words, XOR checksum) from a
// byte stream and writes it to sequential instruction-memory addresses.
module program_loader #(
    parameter int IMEM_DEPTH = 4096,
    parameter int ADDR_W     = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    program_loader_if.slave       bus,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [2:0]            error_code,
    output logic [12:0]           prog_len
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_INS_HI, S_INS_LO, S_CHECK, S_DONE, S_ERR
    } state_t;

    localparam logic [2:0] E_ZERO_LEN = 3'd1;
    localparam logic [2:0] E_OPCODE   = 3'd2;
    localparam logic [2:0] E_BRANCH   = 3'd3;
    localparam logic [2:0] E_CHECKSUM = 3'd4;
    localparam logic [2:0] E_TOO_LONG = 3'd5;

    state_t        state, state_n;
    logic [15:0]   len_q;
    logic [7:0]    hi_q;
    logic [7:0]    xor_q;
    logic [ADDR_W:0] idx_q;

    logic          acc;
    logic [15:0]   len_w;
    logic [15:0]   word_w;
    logic          is_branch;
    logic          last_word;
    logic          start_acc;
    logic          wr_set;
    logic          done_set;
    logic          err_set;
    logic [2:0]    err_code_n;
    logic          rx_n;

    assign acc       = bus.in_valid && bus.in_ready;
    assign len_w     = {len_q[15:8], bus.in_data};
    assign word_w    = {hi_q, bus.in_data};
    assign is_branch = (hi_q[7:4] == 4'hC) || (hi_q[7:4] == 4'hD);
    assign last_word = (16'(idx_q) + 16'd1) == len_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n    = state;
        start_acc  = 1'b0;
        wr_set     = 1'b0;
        done_set   = 1'b0;
        err_set    = 1'b0;
        err_code_n = 3'd0;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_n   = S_LEN_HI;
                    start_acc = 1'b1;
                end
            end
            S_LEN_HI: if (acc) state_n = S_LEN_LO;
            S_LEN_LO: begin
                if (acc) begin
                    if (len_w == 16'd0) begin
                        err_set    = 1'b1;
                        err_code_n = E_ZERO_LEN;
                    end else if (len_w > 16'(IMEM_DEPTH)) begin
                        err_set    = 1'b1;
                        err_code_n = E_TOO_LONG;
                    end else begin
                        state_n = S_INS_HI;
                    end
                end
            end
            S_INS_HI: begin
                if (acc) begin
                    if (bus.in_data[7:4] == 4'hF) begin
                        err_set    = 1'b1;
                        err_code_n = E_OPCODE;
                    end else begin
                        state_n = S_INS_LO;
                    end
                end
            end
            S_INS_LO: begin
                if (acc) begin
                    // JUMP/CALL targets must land inside the program being loaded
                    if (is_branch && (16'(word_w[11:0]) >= len_q)) begin
                        err_set    = 1'b1;
                        err_code_n = E_BRANCH;
                    end else begin
                        wr_set  = 1'b1;
                        state_n = last_word ? S_CHECK : S_INS_HI;
                    end
                end
            end
            S_CHECK: begin
                if (acc) begin
                    if (bus.in_data == xor_q) begin
                        done_set = 1'b1;
                        state_n  = S_DONE;
                    end else begin
                        err_set    = 1'b1;
                        err_code_n = E_CHECKSUM;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (err_set) state_n = S_ERR;
    end

    // in_ready and busy follow the next state so they drop right after the
    // byte that ends reception
    assign rx_n = (state_n == S_LEN_HI) || (state_n == S_LEN_LO) ||
                  (state_n == S_INS_HI) || (state_n == S_INS_LO) ||
                  (state_n == S_CHECK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.in_ready   <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_data  <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            error_code     <= 3'd0;
            prog_len       <= 13'd0;
            len_q          <= 16'd0;
            hi_q           <= 8'd0;
            xor_q          <= 8'd0;
            idx_q          <= '0;
        end else begin
            bus.in_ready <= rx_n;
            busy         <= rx_n;
            bus.imem_we  <= wr_set;
            done         <= done_set;

            if (start_acc) begin
                error      <= 1'b0;
                error_code <= 3'd0;
                xor_q      <= 8'd0;
                idx_q      <= '0;
                // a reload after a good load keeps the old length visible until it ends
                if (state != S_DONE) prog_len <= 13'd0;
            end

            if (acc && state != S_CHECK) xor_q <= xor_q ^ bus.in_data;
            if (acc && state == S_LEN_HI) len_q[15:8] <= bus.in_data;
            if (acc && state == S_LEN_LO) len_q[7:0]  <= bus.in_data;
            if (acc && state == S_INS_HI) hi_q <= bus.in_data;

            if (wr_set) begin
                bus.imem_addr <= idx_q[ADDR_W-1:0];
                bus.imem_data <= word_w;
                idx_q         <= idx_q + 1'b1;
            end

            if (done_set) prog_len <= len_q[12:0];

            if (err_set) begin
                error      <= 1'b1;
                error_code <= err_code_n;
                prog_len   <= 13'd0;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed frame vectors for program_loader plus reset-mid-frame sequence.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        error;
    logic [2:0]  error_code;
    logic [12:0] prog_len;

    program_loader_if #(.ADDR_W(12)) bus ();

    program_loader #(.IMEM_DEPTH(4096), .ADDR_W(12)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .busy(busy), .done(done), .error(error),
        .error_code(error_code), .prog_len(prog_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0][7:0] b;      // byte i of the frame is b[7-i]
        int              n;
        bit              tog;
        int              acc;
        logic [2:0]      code;
        bit              dn;
        logic [12:0]     pl_start;
        logic [12:0]     pl_end;
        int              nwr;
        logic [15:0]     w0;
        logic [15:0]     w1;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    vec_t vecs [8];

    always @(negedge clk) begin
        if (bus.imem_we) wr_cnt <= wr_cnt + 1;
        if (done)        done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [63:0] b, input int n, input bit tog,
                                input int acc, input logic [2:0] code, input bit dn,
                                input logic [12:0] pl_start, input logic [12:0] pl_end,
                                input int nwr, input logic [15:0] w0, input logic [15:0] w1);
        vec_t v;
        v.b = b; v.n = n; v.tog = tog; v.acc = acc; v.code = code; v.dn = dn;
        v.pl_start = pl_start; v.pl_end = pl_end; v.nwr = nwr; v.w0 = w0; v.w1 = w1;
        return v;
    endfunction

    // Presents one byte; ok=0 if not taken within a few cycles
    task automatic send_byte(input logic [7:0] b, input bit tog, output bit ok);
        ok = 1'b0;
        if (tog) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int  acc, wr0, dn0, k;
        bit  ok;
        logic [15:0] wexp;
        acc = 0; wr0 = wr_cnt; dn0 = done_cnt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("error_cleared", error, 0);
        chk("prog_len_after_start", prog_len, v.pl_start);
        for (int i = 0; i < v.n; i++) begin
            send_byte(v.b[7-i], v.tog, ok);
            if (!ok) break;
            acc++;
            if (i >= 3 && (i % 2) == 1) begin
                k = (i - 3) / 2;
                if (k < v.nwr) begin
                    wexp = (k == 0) ? v.w0 : v.w1;
                    chk("write_strobe", bus.imem_we, 1);
                    chk("write_addr", bus.imem_addr, k);
                    chk("write_data", bus.imem_data, wexp);
                end else begin
                    chk("no_write", bus.imem_we, 0);
                end
            end
            if (i == v.acc - 1 && v.code != 0) chk("error_immediate", error, 1);
            if (i == v.acc - 1 && v.dn) chk("done_pulse", done, 1);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("bytes_accepted", acc, v.acc);
        chk("write_count", wr_cnt - wr0, v.nwr);
        chk("done_count", done_cnt - dn0, v.dn ? 1 : 0);
        chk("error_flag", error, (v.code != 0) ? 1 : 0);
        chk("error_code", error_code, v.code);
        chk("prog_len", prog_len, v.pl_end);
        chk("busy_end", busy, 0);
        chk("in_ready_end", bus.in_ready, 0);
    endtask

    initial begin
        bit ok;
        rst = 1'b1; start = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = 8'h00;

        //             bytes                      n tog acc code dn pl_s pl_e nwr w0       w1
        vecs[0] = mk(64'h00_02_01_05_21_12_35_00, 7, 0, 7, 3'd0, 1, 0, 2, 2, 16'h0105, 16'h2112);
        vecs[1] = mk(64'h00_00_01_00_00_00_00_00, 3, 0, 2, 3'd1, 0, 2, 0, 0, 16'h0000, 16'h0000);
        vecs[2] = mk(64'h00_02_01_05_21_12_35_00, 7, 0, 7, 3'd0, 1, 0, 2, 2, 16'h0105, 16'h2112);
        vecs[3] = mk(64'h00_02_01_05_F0_00_00_00, 6, 0, 5, 3'd2, 0, 2, 0, 1, 16'h0105, 16'h0000);
        vecs[4] = mk(64'h00_01_C0_05_C4_00_00_00, 5, 0, 4, 3'd3, 0, 0, 0, 0, 16'h0000, 16'h0000);
        vecs[5] = mk(64'h00_01_C0_00_C1_00_00_00, 5, 0, 5, 3'd0, 1, 0, 1, 1, 16'hC000, 16'h0000);
        vecs[6] = mk(64'h00_02_01_05_21_12_36_00, 7, 1, 7, 3'd4, 0, 1, 0, 2, 16'h0105, 16'h2112);
        vecs[7] = mk(64'h10_01_00_00_00_00_00_00, 3, 0, 2, 3'd5, 0, 0, 0, 0, 16'h0000, 16'h0000);

        #12;
        chk("reset_in_ready", bus.in_ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_we", bus.imem_we, 0);
        chk("reset_error", error, 0);
        chk("reset_prog_len", prog_len, 0);
        rst = 1'b0;

        for (int v = 0; v < 8; v++) run_vec(vecs[v]);

        // Reset after the fourth byte of a good frame, then reload
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(vecs[0].b[7-i], 1'b0, ok);
        chk("pre_reset_write", bus.imem_we, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_in_ready", bus.in_ready, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_we", bus.imem_we, 0);
        chk("async_rst_addr", bus.imem_addr, 0);
        chk("async_rst_data", bus.imem_data, 0);
        chk("async_rst_error", {error, error_code}, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_prog_len", prog_len, 0);
        #4 rst = 1'b0;
        run_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
